kp_gaussian: RTL and testbench

Pipelined 3x3 Gaussian blur stage in the colour-detect keypoint path. It consumes the three-row, three-pixel window beats produced by the kernel-control line-buffer stage and emits one smoothed greyscale pixel per input beat. It also tags each output with start-of-frame, end-of-line and end-of-frame markers for the downstream stage. The kernel is fixed at [1 2 1; 2 4 2; 1 2 1] / 16, with round-half-up.

---
 rtl/kp_gaussian.sv | 98 +++++++++
 tb/tb_kp_gaussian.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/kp_gaussian.sv
// 3x3 Gaussian blur ([1 2 1; 2 4 2; 1 2 1] / 16, round-half-up) on window beats,
// three-stage pipeline with sof/eol/eof tagging from free-running column/row counters.
module kp_gaussian #(
    parameter int DATA_WIDTH  = 8,
    parameter int LINE_LENGTH = 640,
    parameter int LINE_COUNT  = 480
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [3*DATA_WIDTH-1:0] i_r0_data,
    input  logic [3*DATA_WIDTH-1:0] i_r1_data,
    input  logic [3*DATA_WIDTH-1:0] i_r2_data,
    input  logic                    i_valid,
    output logic [DATA_WIDTH-1:0]   o_data,
    output logic                    o_valid,
    output logic                    o_sof,
    output logic                    o_eol,
    output logic                    o_eof
);
    localparam int DW = DATA_WIDTH;
    localparam int HW = DW + 2;
    localparam int VW = DW + 4;
    localparam int CW = (LINE_LENGTH > 1) ? $clog2(LINE_LENGTH) : 1;
    localparam int RW = (LINE_COUNT > 1) ? $clog2(LINE_COUNT) : 1;

    logic [2:0][3*DW-1:0] w_rows;
    logic [2:0][HW-1:0]   w_h;
    logic [2:0][HW-1:0]   r_h;
    logic [VW-1:0]        w_v;
    logic [VW-1:0]        r_v;
    logic [VW-1:0]        w_rnd;
    logic [2:0]           r_vld;
    logic [CW-1:0]        r_col;
    logic [RW-1:0]        r_row;
    logic                 w_col_last;
    logic                 w_row_last;

    assign w_rows = {i_r2_data, i_r1_data, i_r0_data};

    // Horizontal [1 2 1] per window row.
    for (genvar k = 0; k < 3; k++) begin : g_hsum
        assign w_h[k] = HW'(w_rows[k][3*DW-1:2*DW])
                      + (HW'(w_rows[k][2*DW-1:DW]) << 1)
                      + HW'(w_rows[k][DW-1:0]);
    end

    assign w_v        = VW'(r_h[0]) + (VW'(r_h[1]) << 1) + VW'(r_h[2]);
    assign w_rnd      = r_v + VW'(8);
    assign w_col_last = (r_col == CW'(LINE_LENGTH - 1));
    assign w_row_last = (r_row == RW'(LINE_COUNT - 1));
    assign o_valid    = r_vld[2];

    // Data stages capture every cycle; only the valid shift register tracks beats.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_h   <= '0;
            r_v   <= '0;
            r_vld <= '0;
        end else begin
            r_h   <= w_h;
            r_v   <= w_v;
            r_vld <= {r_vld[1:0], i_valid};
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (r_vld[1]) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= w_row_last ? '0 : r_row + RW'(1);
            end else begin
                r_col <= r_col + CW'(1);
            end
        end
    end

    // Markers register alongside o_data from the stage-2 valid bit.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_data <= '0;
            o_sof  <= 1'b0;
            o_eol  <= 1'b0;
            o_eof  <= 1'b0;
        end else if (r_vld[1]) begin
            o_data <= w_rnd[VW-1:4];
            o_sof  <= (r_col == '0) && (r_row == '0);
            o_eol  <= w_col_last;
            o_eof  <= w_col_last && w_row_last;
        end else begin
            o_sof  <= 1'b0;
            o_eol  <= 1'b0;
            o_eof  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_kp_gaussian.sv
// Directed bench for kp_gaussian: table-driven pixel vectors plus hand-written
// latency, bubble, marker and mid-frame reset sequences (4x3 frame geometry).
module tb_kp_gaussian;
    localparam int DW = 8;
    localparam int LL = 4;
    localparam int LC = 3;

    typedef struct {
        logic [3*DW-1:0] r0;
        logic [3*DW-1:0] r1;
        logic [3*DW-1:0] r2;
        logic [DW-1:0]   exp;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [3*DW-1:0] r0 = '0, r1 = '0, r2 = '0;
    logic            vld = 1'b0;
    logic [DW-1:0]   o_data;
    logic            o_valid, o_sof, o_eol, o_eof;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int stray = 0;
    int q_data[$];
    int q_cyc[$];
    bit q_sof[$], q_eol[$], q_eof[$];

    kp_gaussian #(.DATA_WIDTH(DW), .LINE_LENGTH(LL), .LINE_COUNT(LC)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_r0_data(r0), .i_r1_data(r1), .i_r2_data(r2), .i_valid(vld),
        .o_data(o_data), .o_valid(o_valid),
        .o_sof(o_sof), .o_eol(o_eol), .o_eof(o_eof)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (o_valid) begin
            q_data.push_back(int'(o_data));
            q_cyc.push_back(cyc);
            q_sof.push_back(o_sof);
            q_eol.push_back(o_eol);
            q_eof.push_back(o_eof);
        end else if (o_sof || o_eol || o_eof) begin
            stray++;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [3*DW-1:0] a, input logic [3*DW-1:0] b,
                        input logic [3*DW-1:0] c);
        r0 = a; r1 = b; r2 = c; vld = 1'b1;
        @(posedge clk);
        #1;
        vld = 1'b0;
    endtask

    task automatic flat(input logic [DW-1:0] p);
        beat({3{p}}, {3{p}}, {3{p}});
    endtask

    task automatic clear_q();
        q_data.delete(); q_cyc.delete();
        q_sof.delete(); q_eol.delete(); q_eof.delete();
    endtask

    task automatic do_reset();
        vld = 1'b0; rst = 1'b1;
        idle(2);
        rst = 1'b0;
    endtask

    vec_t tbl[13];
    int   t0;
    int   in_cyc[6];
    int   snap;

    initial begin
        tbl[0]  = '{24'h000000, 24'h000000, 24'h000000, 8'd0};
        tbl[1]  = '{{3{8'd100}}, {3{8'd100}}, {3{8'd100}}, 8'd100};
        tbl[2]  = '{24'h000000, 24'h00FF00, 24'h000000, 8'd64};
        tbl[3]  = '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 8'd255};
        tbl[4]  = '{24'h080000, 24'h000000, 24'h000000, 8'd1};
        tbl[5]  = '{24'h070000, 24'h000000, 24'h000000, 8'd0};
        tbl[6]  = '{24'h180000, 24'h000000, 24'h000000, 8'd2};
        tbl[7]  = '{24'h000000, 24'h000000, 24'h001000, 8'd2};
        tbl[8]  = '{24'hFFFFFF, 24'h000000, 24'h000000, 8'd64};
        tbl[9]  = '{24'h000000, 24'h0A0000, 24'h000000, 8'd1};
        tbl[10] = '{{8'd10, 8'd20, 8'd30}, {8'd40, 8'd50, 8'd60}, {8'd70, 8'd80, 8'd90}, 8'd50};
        tbl[11] = '{24'h000000, 24'hFFFFFF, 24'h000000, 8'd128};
        tbl[12] = '{24'h000000, 24'h000000, 24'h0000FF, 8'd16};

        // Reset state
        idle(3);
        chk("rst_o_data", int'(o_data), 0);
        chk("rst_o_valid", int'(o_valid), 0);
        chk("rst_markers", int'({o_sof, o_eol, o_eof}), 0);
        rst = 1'b0;

        // Table vectors back-to-back; first beat drives in the cycle after release
        clear_q();
        t0 = cyc;
        foreach (tbl[i]) beat(tbl[i].r0, tbl[i].r1, tbl[i].r2);
        idle(6);
        chk("tbl_count", q_data.size(), 13);
        if (q_data.size() == 13) begin
            chk("tbl_latency", q_cyc[0] - t0, 3);
            foreach (tbl[i]) chk($sformatf("tbl[%0d]", i), q_data[i], int'(tbl[i].exp));
        end

        // Uniform 100 for 10 beats: 10 consecutive outputs
        clear_q();
        t0 = cyc;
        repeat (10) flat(8'd100);
        idle(6);
        chk("uni_count", q_data.size(), 10);
        if (q_data.size() == 10) begin
            chk("uni_latency", q_cyc[0] - t0, 3);
            for (int i = 0; i < 10; i++) begin
                chk($sformatf("uni_data[%0d]", i), q_data[i], 100);
                chk($sformatf("uni_cyc[%0d]", i), q_cyc[i] - q_cyc[0], i);
            end
        end

        // Bubbles 1,0,1,1,0,1
        clear_q();
        in_cyc[0] = cyc; flat(8'd11);
        idle(1);
        in_cyc[2] = cyc; flat(8'd33);
        in_cyc[3] = cyc; flat(8'd44);
        idle(1);
        in_cyc[5] = cyc; flat(8'd66);
        idle(6);
        chk("bub_count", q_data.size(), 4);
        if (q_data.size() == 4) begin
            chk("bub_d0", q_data[0], 11);  chk("bub_c0", q_cyc[0] - in_cyc[0], 3);
            chk("bub_d1", q_data[1], 33);  chk("bub_c1", q_cyc[1] - in_cyc[2], 3);
            chk("bub_d2", q_data[2], 44);  chk("bub_c2", q_cyc[2] - in_cyc[3], 3);
            chk("bub_d3", q_data[3], 66);  chk("bub_c3", q_cyc[3] - in_cyc[5], 3);
        end

        // Markers: 12-beat frame with random gaps, then next frame's first beat
        do_reset();
        clear_q();
        for (int i = 0; i < 13; i++) begin
            flat(8'(i * 10));
            idle($urandom_range(0, 2));
        end
        idle(6);
        chk("mk_count", q_data.size(), 13);
        if (q_data.size() == 13) begin
            for (int i = 0; i < 13; i++) begin
                chk($sformatf("mk_data[%0d]", i), q_data[i], i * 10);
                chk($sformatf("mk_sof[%0d]", i), int'(q_sof[i]), int'(i == 0 || i == 12));
                chk($sformatf("mk_eol[%0d]", i), int'(q_eol[i]), int'(i == 3 || i == 7 || i == 11));
                chk($sformatf("mk_eof[%0d]", i), int'(q_eof[i]), int'(i == 11));
            end
        end

        // Reset mid-frame with beats still in flight
        do_reset();
        clear_q();
        for (int i = 0; i < 6; i++) flat(8'(i + 1));
        snap = q_data.size();
        rst = 1'b1;
        #1;
        chk("mid_async_valid", int'(o_valid), 0);
        chk("mid_async_data", int'(o_data), 0);
        idle(2);
        rst = 1'b0;
        idle(5);
        chk("mid_no_valid", q_data.size(), snap);
        clear_q();
        for (int i = 0; i < 12; i++) flat(8'(200 + i));
        idle(6);
        chk("mid_count", q_data.size(), 12);
        if (q_data.size() == 12) begin
            chk("mid_sof0", int'(q_sof[0]), 1);
            chk("mid_eof11", int'(q_eof[11]), 1);
            chk("mid_eol3", int'(q_eol[3]), 1);
            chk("mid_d0", q_data[0], 200);
            for (int i = 1; i < 11; i++)
                chk($sformatf("mid_sof_eof[%0d]", i), int'({q_sof[i], q_eof[i]}), 0);
        end

        chk("stray_markers", stray, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
